// File: rtl/pipelined_functional_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_functional_unit
// Description : Fully pipelined integer ALU functional unit. Ops are accepted
//               one per cycle, computed over a LATENCY-stage pipe and
//               collected in an in-order output buffer that drains to either
//               the wakeup bus or the LSQ address bus. Buffer space is
//               reserved at issue (credit), so the pipe never stalls.
//               Optional feature macro: FU_ILLEGAL_OP_EN (adds illegal_op).
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_functional_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 6,
  parameter int ROB_W     = 6,
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       alu_control,
  input  logic             alu_src,
  input  logic             is_for_lsq,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_value,
  input  logic [XLEN-1:0]  rs2_value,
  input  logic [TAG_W-1:0] tag,
  input  logic [ROB_W-1:0] rob_index,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [ROB_W-1:0] wb_rob_index,
  output logic [XLEN-1:0]  wb_value,
  output logic             lsq_valid,
  input  logic             lsq_ready,
  output logic [ROB_W-1:0] lsq_rob_index,
  output logic [XLEN-1:0]  lsq_value
`ifdef FU_ILLEGAL_OP_EN
  ,
  output logic             illegal_op
`endif
);

  localparam int c_SH_W  = $clog2(XLEN);
  localparam int c_PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(OUT_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(OUT_DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(OUT_DEPTH - 1);

  localparam logic [3:0] c_OP_NONE0 = 4'b0000;
  localparam logic [3:0] c_OP_OR    = 4'b0001;
  localparam logic [3:0] c_OP_ADD   = 4'b0010;
  localparam logic [3:0] c_OP_XOR   = 4'b0011;
  localparam logic [3:0] c_OP_SUB   = 4'b0100;
  localparam logic [3:0] c_OP_AND   = 4'b0101;
  localparam logic [3:0] c_OP_SLL   = 4'b0110;
  localparam logic [3:0] c_OP_SRL   = 4'b0111;
  localparam logic [3:0] c_OP_SRA   = 4'b1011;
  localparam logic [3:0] c_OP_SLT   = 4'b1100;
  localparam logic [3:0] c_OP_SLTU  = 4'b1101;
  localparam logic [3:0] c_OP_LUI   = 4'b1110;
  localparam logic [3:0] c_OP_NONE1 = 4'b1111;

  typedef struct packed {
    logic             lsq;
    logic [ROB_W-1:0] rob;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } entry_t;

  localparam entry_t c_RESET_ENTRY = '{lsq: 1'b0, rob: '1, tag: '0, value: '1};

  logic [XLEN-1:0]    w_rhs;
  logic [c_SH_W-1:0]  w_shamt;
  logic [XLEN-1:0]    w_result;
  logic               w_accept;
  logic               w_write;
  logic               w_pop;
  entry_t             w_new_entry;
  entry_t             w_head;
  logic               w_head_valid;

  entry_t             r_pipe [LATENCY];
  logic [LATENCY-1:0] r_pipe_valid;
  entry_t             r_buf [OUT_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] r_occ;

`ifdef FU_ILLEGAL_OP_EN
  logic               w_illegal;
`endif

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // Credit check depends on registered occupancy only, never on a same-cycle pop.
  assign issue_ready = (r_occ < c_DEPTH);
  assign w_accept    = issue_valid && issue_ready && !flush;

  // ALU: operand select and opcode decode; unknown opcodes yield all-ones.
  always_comb begin
    w_rhs    = alu_src ? imm : rs2_value;
    w_shamt  = w_rhs[c_SH_W-1:0];
    w_result = '1;
`ifdef FU_ILLEGAL_OP_EN
    w_illegal = 1'b0;
`endif
    case (alu_control)
      c_OP_OR:   w_result = rs1_value | w_rhs;
      c_OP_ADD:  w_result = rs1_value + w_rhs;
      c_OP_XOR:  w_result = rs1_value ^ w_rhs;
      c_OP_SUB:  w_result = rs1_value - w_rhs;
      c_OP_AND:  w_result = rs1_value & w_rhs;
      c_OP_SLL:  w_result = rs1_value << w_shamt;
      c_OP_SRL:  w_result = rs1_value >> w_shamt;
      c_OP_SRA:  w_result = $unsigned($signed(rs1_value) >>> w_shamt);
      c_OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(rs1_value) < $signed(w_rhs))};
      c_OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (rs1_value < w_rhs)};
      c_OP_LUI:  w_result = w_rhs;
      c_OP_NONE0, c_OP_NONE1: w_result = '1;
      default: begin
        w_result = '1;
`ifdef FU_ILLEGAL_OP_EN
        w_illegal = 1'b1;
`endif
      end
    endcase
  end

  assign w_new_entry = '{lsq: is_for_lsq, rob: rob_index, tag: tag, value: w_result};

  // Fixed-latency result pipe; flush kills every stage, data is left in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= c_RESET_ENTRY;
    end else begin
      r_pipe_valid[0] <= w_accept;
      if (w_accept) r_pipe[0] <= w_new_entry;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1] && !flush;
        r_pipe[i]       <= r_pipe[i-1];
      end
    end
  end

  assign w_write      = r_pipe_valid[LATENCY-1] && !flush;
  assign w_head       = r_buf[r_rd_ptr];
  assign w_head_valid = (r_count != '0);

  assign wb_valid      = w_head_valid && !w_head.lsq;
  assign lsq_valid     = w_head_valid &&  w_head.lsq;
  assign wb_tag        = w_head.tag;
  assign wb_rob_index  = w_head.rob;
  assign wb_value      = w_head.value;
  assign lsq_rob_index = w_head.rob;
  assign lsq_value     = w_head.value;
  assign w_pop         = (wb_valid && wb_ready) || (lsq_valid && lsq_ready);

  // In-order output FIFO; only the head is presented to either bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) r_buf[i] <= c_RESET_ENTRY;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_buf[r_wr_ptr] <= r_pipe[LATENCY-1];
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Occupancy counts every op from accept until its pop (pipe plus buffer).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FU_ILLEGAL_OP_EN
  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_op <= 1'b0;
    else if (w_accept && w_illegal) illegal_op <= 1'b1;
  end

`ifndef SYNTHESIS
  // Report each accepted illegal opcode in simulation.
  always_ff @(posedge clk) begin
    if (!reset && w_accept && w_illegal) $error("illegal opcode %b accepted", alu_control);
  end
`endif
`endif

`ifndef SYNTHESIS
  // Credit scheme must make buffer overflow impossible.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(w_write && !w_pop && r_count == c_DEPTH))
        else $error("output buffer overflow");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_functional_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_functional_unit
// Description : Self-checking bench; directed scenarios plus random traffic
//               compared every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_functional_unit;

  localparam int XLEN = 32, TAG_W = 6, ROB_W = 6, LATENCY = 2, OUT_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush, issue_valid, alu_src, is_for_lsq, wb_ready, lsq_ready;
  logic [3:0]       alu_control;
  logic [XLEN-1:0]  imm, rs1_value, rs2_value;
  logic [TAG_W-1:0] tag;
  logic [ROB_W-1:0] rob_index;
  logic             issue_ready, wb_valid, lsq_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [ROB_W-1:0] wb_rob_index, lsq_rob_index;
  logic [XLEN-1:0]  wb_value, lsq_value;
`ifdef FU_ILLEGAL_OP_EN
  logic             illegal_op;
`endif

  pipelined_functional_unit #(
    .XLEN(XLEN), .TAG_W(TAG_W), .ROB_W(ROB_W), .LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .alu_control(alu_control), .alu_src(alu_src), .is_for_lsq(is_for_lsq),
    .imm(imm), .rs1_value(rs1_value), .rs2_value(rs2_value),
    .tag(tag), .rob_index(rob_index),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .wb_rob_index(wb_rob_index), .wb_value(wb_value),
    .lsq_valid(lsq_valid), .lsq_ready(lsq_ready),
    .lsq_rob_index(lsq_rob_index), .lsq_value(lsq_value)
`ifdef FU_ILLEGAL_OP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  v;
    logic [TAG_W-1:0] t;
    logic [ROB_W-1:0] r;
    logic             l;
    int               vis;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference ALU written directly from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic [31:0] r;
    logic [31:0] ones;
    sh = int'(b[4:0]);
    ones = 32'hFFFF_FFFF;
    case (op)
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h3: r = a ^ b;
      4'h4: r = a - b;
      4'h5: r = a & b;
      4'h6: r = a << sh;
      4'h7: r = a >> sh;
      4'hB: begin
        r = a >> sh;
        if (a[31]) r = r | ~(ones >> sh);
      end
      4'hC: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hD: r = (a < b) ? 32'd1 : 32'd0;
      4'hE: r = b;
      default: r = ones;
    endcase
    return r;
  endfunction

  // One clock cycle: compare DUT against model, then advance both.
  task automatic step();
    logic exp_ready, head_vis, exp_wb, exp_lsq, acc, pop;
    exp_t e;
    exp_ready = (q.size() < OUT_DEPTH);
    head_vis  = (q.size() > 0) && (q[0].vis <= cyc);
    exp_wb    = head_vis && !q[0].l;
    exp_lsq   = head_vis &&  q[0].l;
    check("issue_ready", 32'(issue_ready), 32'(exp_ready));
    check("wb_valid", 32'(wb_valid), 32'(exp_wb));
    check("lsq_valid", 32'(lsq_valid), 32'(exp_lsq));
    if (exp_wb) begin
      check("wb_value", wb_value, q[0].v);
      check("wb_tag", 32'(wb_tag), 32'(q[0].t));
      check("wb_rob_index", 32'(wb_rob_index), 32'(q[0].r));
    end
    if (exp_lsq) begin
      check("lsq_value", lsq_value, q[0].v);
      check("lsq_rob_index", 32'(lsq_rob_index), 32'(q[0].r));
    end
`ifdef FU_ILLEGAL_OP_EN
    check("illegal_op", 32'(illegal_op), 32'd0);
`endif
    acc = issue_valid && exp_ready && !flush;
    pop = (exp_wb && wb_ready) || (exp_lsq && lsq_ready);
    e.v   = ref_alu(alu_control, rs1_value, alu_src ? imm : rs2_value);
    e.t   = tag;
    e.r   = rob_index;
    e.l   = is_for_lsq;
    @(posedge clk);
    cyc++;
    e.vis = cyc + LATENCY;
    if (pop) void'(q.pop_front());
    if (flush) q.delete();
    if (acc) q.push_back(e);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic src, input logic lsq, input logic [5:0] t, input logic [5:0] r);
    issue_valid = 1'b1;
    alu_control = op;
    rs1_value   = a;
    if (src) begin imm = b; rs2_value = 32'hDEAD_BEEF; end
    else     begin rs2_value = b; imm = 32'hDEAD_BEEF; end
    alu_src     = src;
    is_for_lsq  = lsq;
    tag         = t;
    rob_index   = r;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [3:0] op;
    flush = 0; issue_valid = 0; alu_src = 0; is_for_lsq = 0; wb_ready = 0; lsq_ready = 0;
    alu_control = 0; imm = 0; rs1_value = 0; rs2_value = 0; tag = 0; rob_index = 0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_lsq_valid", 32'(lsq_valid), 32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);

    // Single ADD with fixed latency.
    wb_ready = 1;
    set_op(4'h2, 32'd5, 32'd7, 0, 0, 6'd3, 6'd9);
    step();
    idle(1);
    check("add_not_early", 32'(wb_valid), 32'd0);
    step();
    check("add_wb_valid", 32'(wb_valid), 32'd1);
    check("add_wb_value", wb_value, 32'd12);
    check("add_wb_tag", 32'(wb_tag), 32'd3);
    check("add_wb_rob", 32'(wb_rob_index), 32'd9);
    idle(2);

    // Back-to-back ops, one result per cycle.
    set_op(4'h4, 32'd3, 32'd5, 0, 0, 6'd1, 6'd1); step();
    set_op(4'hB, 32'h8000_0000, 32'd4, 1, 0, 6'd2, 6'd2); step();
    set_op(4'hC, 32'hFFFF_FFFF, 32'd1, 0, 0, 6'd3, 6'd3); step();
    set_op(4'hE, 32'd0, 32'h1234_5000, 1, 0, 6'd4, 6'd4); step();
    idle(6);

    // Credit exhaustion with wb blocked, then drain.
    wb_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_op(4'h1, 32'(i), 32'h100, 0, 0, 6'(i + 10), 6'(i + 10)); step();
    end
    check("credit_full", 32'(issue_ready), 32'd0);
    set_op(4'h1, 32'hAA, 32'h55, 0, 0, 6'd20, 6'd20); step(); step();
    issue_valid = 0;
    idle(2);
    wb_ready = 1;
    idle(6);

    // LSQ head blocks a following wb result.
    wb_ready = 1; lsq_ready = 0;
    set_op(4'h2, 32'h1000, 32'h10, 0, 1, 6'd5, 6'd21); step();
    set_op(4'h3, 32'hF0F0, 32'h0FF0, 0, 0, 6'd6, 6'd22); step();
    idle(3);
    check("lsq_block_value", lsq_value, 32'h1010);
    check("lsq_block_wb", 32'(wb_valid), 32'd0);
    lsq_ready = 1;
    idle(4);

    // Flush with a simultaneous issue.
    wb_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_op(4'h2, 32'(i), 32'd1, 0, i[0], 6'(i), 6'(i)); step();
    end
    set_op(4'h2, 32'd9, 32'd9, 0, 0, 6'd7, 6'd7);
    flush = 1;
    step();
    flush = 0;
    issue_valid = 0;
    check("flush_ready", 32'(issue_ready), 32'd1);
    idle(3);
    wb_ready = 1;
    set_op(4'h2, 32'd1, 32'd1, 0, 0, 6'd8, 6'd8); step();
    idle(1);
    step();
    check("post_flush_add", wb_value, 32'd2);
    idle(2);

`ifndef FU_ILLEGAL_OP_EN
    // Illegal opcode returns all-ones.
    set_op(4'h8, 32'd1, 32'd2, 0, 0, 6'd9, 6'd9); step();
    idle(4);
`endif

    // Random traffic with flushes and one mid-run reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        reset = 1'b1;
        #2 reset = 1'b0;
        q.delete();
      end
      op = 4'($urandom_range(0, 15));
`ifdef FU_ILLEGAL_OP_EN
      if (op == 4'h8 || op == 4'h9 || op == 4'hA) op = 4'h2;
`endif
      set_op(op,
             ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | 32'($urandom_range(0, 15)) : $urandom,
             ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      issue_valid = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 29) == 0);
      wb_ready    = ($urandom_range(0, 3) != 0);
      lsq_ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_functional_unit.md
Name: pipelined_functional_unit

Overview:
Parametrised, fully pipelined integer FU for the out-of-order core. It accepts one ALU op per cycle from the issue stage and computes the result over a fixed LATENCY-stage pipeline. Results go into an in-order output buffer, which drains through valid/ready handshakes to either the wakeup bus or the LSQ address bus. A credit scheme guarantees no result is ever dropped when the bus arbiters withhold a grant; flush discards all speculative work.

Parameters:
XLEN, 32, datapath width (power of two, >=8)
TAG_W, 6, physical tag width
ROB_W, 6, ROB index width
LATENCY, 2, issue-to-buffer pipeline depth in cycles (>=1)
OUT_DEPTH, 4, total ops in flight plus buffered (>=1; >=LATENCY+1 for full throughput)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous discard of all in-flight and buffered ops
issue_valid  in  1  issue stage presents an op
issue_ready  out  1  FU can accept an op this cycle
alu_control  in  4  opcode
alu_src  in  1  0: rhs=rs2_value, 1: rhs=imm
is_for_lsq  in  1  route result to LSQ bus instead of wakeup bus
imm, rs1_value, rs2_value  in  XLEN each  operands
tag  in  TAG_W  destination tag
rob_index  in  ROB_W  ROB entry
wb_valid  out  1  head result for wakeup bus
wb_ready  in  1  wakeup bus grant
wb_tag  out  TAG_W; wb_rob_index  out  ROB_W; wb_value  out  XLEN
lsq_valid  out  1  head result for LSQ bus
lsq_ready  in  1  LSQ bus grant
lsq_rob_index  out  ROB_W; lsq_value  out  XLEN

Behaviour:
- Reset is asynchronous and active-high, clock is clk. Reset clears all pipeline valids, buffer count and occupancy. Buffer and pipe data reset to value all-ones, tag 0, rob_index all-ones. After reset: wb_valid=0, lsq_valid=0, issue_ready=1.
- Accept condition: issue_valid && issue_ready && !flush at a rising edge. The result enters the buffer exactly LATENCY edges after acceptance, so it is visible on an output at the earliest LATENCY cycles after the accept edge.
- Opcodes: 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 AND, 0110 SLL, 0111 SRL, 1011 SRA, 1100 SLT (signed, result 0/1), 1101 SLTU, 1110 LUI (result=rhs). 0000 and 1111 are NONE and return all-ones. All other opcodes are illegal and return all-ones. Shifts use rhs[log2(XLEN)-1:0]. Arithmetic wraps modulo 2^XLEN.
- Output buffer: in-order FIFO; only the head is presented.
  - Head with is_for_lsq=0 drives wb_valid=1, lsq_valid=0. Head with is_for_lsq=1 drives the reverse.
  - The head pops on (wb_valid&&wb_ready) or (lsq_valid&&lsq_ready).
  - A head that is not granted blocks later results of either route.
  - Output data fields are combinational from the head entry and are don't-care while the matching valid is low.
- Credit: occupancy = ops in pipeline + buffer entries. issue_ready = (occupancy < OUT_DEPTH), a registered-state function only; a same-cycle pop does not raise issue_ready, so there is no ready-to-ready combinational path. Simultaneous accept and pop leaves occupancy unchanged.
- The pipeline never stalls: space is reserved at issue, so buffer overflow cannot occur (assertion in simulation).
- Flush: on the edge with flush=1, all pipe valids, buffer entries and occupancy clear. The next cycle shows wb_valid=lsq_valid=0 and issue_ready=1. A grant given in the flush cycle still completes its pop, and the bus owner sees the transfer. An issue in the flush cycle is dropped.
- Reset mid-operation: all ops are lost and there are no outputs until new issues arrive.

Optional Feature:
FU_ILLEGAL_OP_EN
- Defined: adds output illegal_op (1 bit), reset 0. It is set sticky on accepting an op with an illegal opcode and cleared only by reset. A simulation $error is reported on that accept.
- Undefined: no port is added, and illegal opcodes silently produce all-ones results.

Test Plan:
- Reset, then issue ADD rs1=5 rs2=7 tag=3 rob=9 with wb_ready=1 held -> wb_valid=1 exactly 2 cycles after accept, wb_value=12, wb_tag=3, wb_rob_index=9; lsq_valid stays 0.
- Back-to-back ops SUB 3-5, SRA 0x80000000>>>4 (alu_src=1, imm=4), SLT -1<1, LUI imm=0x12345000, with wb_ready=1 -> one result per cycle, in order: 0xFFFFFFFE, 0xF8000000, 1, 0x12345000.
- wb_ready=0, issue 4 ORs -> issue_ready drops to 0 after the 4th accept. Raise wb_ready -> 4 results drain in order, and issue_ready returns 1 the cycle after the first pop.
- Head is an LSQ-bound ADD 0x1000+0x10 with lsq_ready=0, followed by a wb-bound XOR -> wb_valid stays 0 while lsq_valid=1 and lsq_value=0x1010. After lsq_ready=1 the XOR appears on wb next cycle.
- Fill 3 ops, assert flush for one cycle with a simultaneous issue_valid -> no further wb_valid/lsq_valid, issue_ready=1 next cycle; a new ADD 1+1 then returns 2 on schedule.
- Issue opcode 1000 -> result all-ones; with FU_ILLEGAL_OP_EN, illegal_op=1 from the next cycle until reset.
